// File: rtl/mem_access_hs_if.sv
// Data-memory port of the MEM stage: request/grant/response bus plus a
// debug view of the access FSM.
//
// Handshake: the master holds req high with addr/we/wdata/be stable until a
// cycle in which gnt is also high; that cycle transfers the request. A load
// is answered later by exactly one rvalid cycle carrying rdata (never in the
// grant cycle). rvalid with no load outstanding is ignored by the master.
interface mem_access_hs_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  // 1 while the master is waiting for load data (WAIT_RSP).
  logic              dbg_wait_rsp;

  modport master (
    output req, we, addr, wdata, be, dbg_wait_rsp,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be, dbg_wait_rsp,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_access_hs.sv
// MEM pipeline stage with a variable-latency data-memory handshake.
// Decodes size/sign, flags illegal or misaligned accesses, stalls the
// pipeline while an access is in flight and aborts hung accesses.
module mem_access_hs #(
  parameter int ADDR_W   = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_exe_mem,
  input  logic              mem_read_exe_mem,
  input  logic              mem_write_exe_mem,
  input  logic              mem_to_reg_exe_mem,
  input  logic              reg_write_exe_mem,
  input  logic [2:0]        funct3_exe_mem,
  input  logic [ADDR_W-1:0] alu_out_exe_mem,
  input  logic [31:0]       w_data_exe_mem,
  input  logic [REG_AW-1:0] write_reg_exe_mem,
  mem_access_hs_if.master   dmem,
  output logic              stall_mem,
  output logic [31:0]       r_data_mem_wb,
  output logic [ADDR_W-1:0] reg_out_mem_wb,
  output logic              mem_to_reg_mem_wb,
  output logic              reg_write_mem_wb,
  output logic [REG_AW-1:0] write_reg_mem_wb,
  output logic              valid_mem_wb,
  output logic              mem_fault_mem_wb
);

  // Counter only needs to reach MAX_WAIT-1; the abort fires on that cycle.
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lane_q;
  logic [2:0]       funct3_q;

  logic memop, is_load, is_store, f3_legal, misaligned, bad_access, legal_memop;
  logic waiting, timeout, complete, op_fault, load_done;
  logic [31:0] shifted, load_ext;

  // Decode the EX/MEM slot: kind of access and whether it may be issued.
  always_comb begin
    memop    = valid_exe_mem & (mem_read_exe_mem | mem_write_exe_mem);
    is_load  = mem_read_exe_mem;
    is_store = mem_write_exe_mem & ~mem_read_exe_mem;
    case (funct3_exe_mem)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = is_load;
      default:                f3_legal = 1'b0;
    endcase
    misaligned  = ((funct3_exe_mem[1:0] == 2'b01) & alu_out_exe_mem[0]) |
                  ((funct3_exe_mem[1:0] == 2'b10) & (alu_out_exe_mem[1:0] != 2'b00));
    bad_access  = memop & (~f3_legal | misaligned);
    legal_memop = memop & ~bad_access;
  end

  // Progress, watchdog and completion of the current slot.
  always_comb begin
    waiting   = 1'b0;
    complete  = 1'b1;
    op_fault  = bad_access;
    load_done = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        waiting  = legal_memop & ~dmem.gnt;
        timeout  = (MAX_WAIT != 0) && waiting && (cnt_q == CNT_LAST);
        complete = ~legal_memop | (dmem.gnt & is_store) | timeout;
        op_fault = bad_access | timeout;
      end
      WAIT_RSP: begin
        waiting   = ~dmem.rvalid;
        timeout   = (MAX_WAIT != 0) && waiting && (cnt_q == CNT_LAST);
        complete  = dmem.rvalid | timeout;
        op_fault  = timeout;
        load_done = dmem.rvalid;
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a granted load waits for its response or the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (legal_memop & dmem.gnt & is_load) state_d = WAIT_RSP;
      WAIT_RSP: if (dmem.rvalid | timeout)            state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: request, lane steering and stall.
  always_comb begin
    dmem.req          = rst_n & (state_q == IDLE) & legal_memop;
    dmem.we           = is_store;
    dmem.addr         = {alu_out_exe_mem[ADDR_W-1:2], 2'b00};
    dmem.dbg_wait_rsp = (state_q == WAIT_RSP);
    case (funct3_exe_mem[1:0])
      2'b00: begin
        dmem.wdata = {4{w_data_exe_mem[7:0]}};
        dmem.be    = 4'b0001 << alu_out_exe_mem[1:0];
      end
      2'b01: begin
        dmem.wdata = {2{w_data_exe_mem[15:0]}};
        dmem.be    = 4'b0011 << {alu_out_exe_mem[1], 1'b0};
      end
      default: begin
        dmem.wdata = w_data_exe_mem;
        dmem.be    = 4'b1111;
      end
    endcase
    stall_mem = rst_n & ~complete;
  end

  // Wait counter: restarts on any state change, completion or idle cycle.
  always_comb begin
    if ((state_d != state_q) || complete || !waiting || (MAX_WAIT == 0)) cnt_d = '0;
    else                                                                  cnt_d = cnt_q + CNT_W'(1);
  end

  // Wait counter register and load-lane capture at the grant of a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      lane_q   <= 2'b00;
      funct3_q <= 3'b000;
    end else begin
      cnt_q <= cnt_d;
      if ((state_q == IDLE) & legal_memop & dmem.gnt & is_load) begin
        lane_q   <= alu_out_exe_mem[1:0];
        funct3_q <= funct3_exe_mem;
      end
    end
  end

  // Load alignment and extension using the lane captured at grant time.
  always_comb begin
    shifted = dmem.rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = dmem.rdata;
    endcase
  end

  // MEM/WB register: result on completion, bubble on stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_mem_wb     <= '0;
      reg_out_mem_wb    <= '0;
      mem_to_reg_mem_wb <= 1'b0;
      reg_write_mem_wb  <= 1'b0;
      write_reg_mem_wb  <= '0;
      valid_mem_wb      <= 1'b0;
      mem_fault_mem_wb  <= 1'b0;
    end else if (complete) begin
      r_data_mem_wb     <= load_done ? load_ext : 32'd0;
      reg_out_mem_wb    <= alu_out_exe_mem;
      mem_to_reg_mem_wb <= mem_to_reg_exe_mem;
      reg_write_mem_wb  <= reg_write_exe_mem & valid_exe_mem & ~op_fault;
      write_reg_mem_wb  <= write_reg_exe_mem;
      valid_mem_wb      <= valid_exe_mem;
      mem_fault_mem_wb  <= op_fault;
    end else begin
      valid_mem_wb      <= 1'b0;
      reg_write_mem_wb  <= 1'b0;
      mem_fault_mem_wb  <= 1'b0;
    end
  end

endmodule
